// File: rtl/ysyx_22041752_refill_arbiter_pkg.sv
// Shared types and widths for the ICACHE/DCACHE refill arbiter.
// Optional feature macro: YSYX_22041752_ARB_RR_EN (round-robin arbitration).
package ysyx_22041752_refill_arbiter_pkg;

    localparam int unsigned SRAM_ADDR_WD = 32;
    localparam int unsigned SRAM_DATA_WD = 64;
    // A 128-bit cache line split into SRAM-width beats
    localparam int unsigned ARB_BEATS    = 128 / SRAM_DATA_WD;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_OWN_I = 1'b0,
        ARB_OWN_D = 1'b1
    } arb_own_e;

endpackage

// File: rtl/ysyx_22041752_refill_arb_pick.sv
// Two-input winner select for the refill arbiter, purely combinational.
// YSYX_22041752_ARB_RR_EN defined: alternate against last_grant on contention.
// Undefined: DCACHE has fixed priority and last_grant is ignored.
module ysyx_22041752_refill_arb_pick
    import ysyx_22041752_refill_arbiter_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_grant,
    output logic winner
);

    // Pick the owner of the next burst; only meaningful when a request is present
    always_comb begin
        winner = ARB_OWN_I;
        if (i_req && d_req) begin
`ifdef YSYX_22041752_ARB_RR_EN
            winner = ~last_grant;
`else
            winner = ARB_OWN_D;
`endif
        end else if (d_req) begin
            winner = ARB_OWN_D;
        end
    end

`ifndef YSYX_22041752_ARB_RR_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/ysyx_22041752_refill_arbiter.sv
// Shares the single SRAM refill port between the ICACHE and DCACHE miss engines.
// The port is locked to one owner for a whole line burst; beats go only to it.
// Optional feature macro: YSYX_22041752_ARB_RR_EN (round-robin instead of
// DCACHE-first fixed priority).
module ysyx_22041752_refill_arbiter
    import ysyx_22041752_refill_arbiter_pkg::*;
#(
    parameter int unsigned BEATS  = ARB_BEATS,
    parameter int unsigned CNT_WD = (BEATS > 1) ? $clog2(BEATS) : 1
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_flush,
    input  logic                    i_req,
    input  logic [SRAM_ADDR_WD-1:0] i_addr,
    output logic                    i_ready,
    output logic [SRAM_DATA_WD-1:0] i_rdata,
    output logic                    i_valid,
    input  logic                    d_req,
    input  logic [SRAM_ADDR_WD-1:0] d_addr,
    output logic                    d_ready,
    output logic [SRAM_DATA_WD-1:0] d_rdata,
    output logic                    d_valid,
    output logic                    sram_req,
    input  logic                    sram_ready,
    output logic [SRAM_ADDR_WD-1:0] sram_addr,
    input  logic [SRAM_DATA_WD-1:0] sram_rdata,
    input  logic                    sram_valid
);

    arb_state_e              state_q, state_d;
    arb_own_e                owner_q, last_grant_q;
    logic [SRAM_ADDR_WD-1:0] addr_q;
    logic [CNT_WD-1:0]       beat_cnt_q;
    logic                    drop_q;
    logic                    winner;
    logic                    owner_is_i;
    logic                    last_beat;
    logic                    any_req;

    assign owner_is_i = (owner_q == ARB_OWN_I);
    assign last_beat  = (beat_cnt_q == CNT_WD'(BEATS - 1));
    assign any_req    = i_req | d_req;

    ysyx_22041752_refill_arb_pick u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_grant (last_grant_q),
        .winner     (winner)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ARB_IDLE;
        else        state_q <= state_d;
    end

    // Next state and all outputs; a dropped ICACHE burst is drained silently
    always_comb begin
        state_d   = state_q;
        sram_req  = 1'b0;
        sram_addr = '0;
        i_ready   = 1'b0;
        d_ready   = 1'b0;
        i_valid   = 1'b0;
        d_valid   = 1'b0;
        i_rdata   = '0;
        d_rdata   = '0;
        case (state_q)
            ARB_IDLE: begin
                if (any_req) state_d = ARB_ADDR;
            end
            ARB_ADDR: begin
                sram_req  = 1'b1;
                sram_addr = addr_q;
                if (sram_ready) begin
                    state_d = ARB_DATA;
                    i_ready = owner_is_i & ~drop_q;
                    d_ready = ~owner_is_i;
                end
            end
            ARB_DATA: begin
                if (sram_valid) begin
                    if (owner_is_i) begin
                        i_valid = ~drop_q;
                        i_rdata = drop_q ? '0 : sram_rdata;
                    end else begin
                        d_valid = 1'b1;
                        d_rdata = sram_rdata;
                    end
                    if (last_beat) state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Burst bookkeeping: owner/address capture, beat count, flush drop, fairness
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q      <= ARB_OWN_I;
            last_grant_q <= ARB_OWN_I;
            addr_q       <= '0;
            beat_cnt_q   <= '0;
            drop_q       <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    drop_q <= 1'b0;
                    if (any_req) begin
                        owner_q <= arb_own_e'(winner);
                        addr_q  <= winner ? d_addr : i_addr;
                    end
                end
                ARB_ADDR: begin
                    if (i_flush && owner_is_i) drop_q <= 1'b1;
                    if (sram_ready) beat_cnt_q <= '0;
                end
                ARB_DATA: begin
                    if (i_flush && owner_is_i) drop_q <= 1'b1;
                    if (sram_valid) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        if (last_beat) last_grant_q <= owner_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
